// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: command FIFO and one-at-a-time SPI transaction sequencer feeding spi_controller
module spi_cmd_sequencer #(
   parameter int FIFO_DEPTH_LOG2 = 4,
   parameter int START_TIMEOUT   = 16,
   parameter int GAP_CYCLES      = 4
) (
   input  logic                       sys_clk,
   input  logic                       reset_n,
   input  logic [31:0]                cmd_data,
   input  logic                       cmd_write,
   output logic                       cmd_full,
   output logic [FIFO_DEPTH_LOG2:0]   cmd_level,
   input  logic                       err_clear,
   output logic                       err_overflow,
   output logic                       err_timeout,
   output logic                       seq_idle,
   output logic                       rd_valid,
   output logic [10:0]                rd_addr,
   output logic [7:0]                 rd_data,
   output logic                       dac_request_write,
   output logic [4:0]                 dac_address,
   output logic [11:0]                dac_data,
   output logic                       adc_request_write,
   output logic                       adc_request_read,
   output logic [10:0]                adc_address,
   output logic [7:0]                 adc_data,
   input  logic [7:0]                 adc_data_readback,
   input  logic                       spi_busy
);
   localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
   localparam int LW    = FIFO_DEPTH_LOG2 + 1;
   localparam int TW    = $clog2(START_TIMEOUT + GAP_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE, GAP} state_t;

   state_t                     state, state_next;
   logic [24:0]                mem [DEPTH];
   logic [24:0]                cmd;
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0]              level;
   logic [TW-1:0]              timer;
   logic [1:0]                 op;
   logic                       empty, pop, push, overflow_set, timeout_set;
   logic                       unused_bits;

   // Only op, address and data are stored; the remaining command bits are don't-care.
   assign unused_bits  = ^{cmd_data[29:27], cmd_data[15:12]};
   assign empty        = level == '0;
   assign cmd_full     = level == LW'(DEPTH);
   assign cmd_level    = level;
   assign pop          = state == IDLE && !empty;
   assign push         = cmd_write && (!cmd_full || pop);
   assign overflow_set = cmd_write && cmd_full && !pop;
   assign op           = cmd[24:23];

   assign dac_request_write = state == ISSUE && op == 2'b00;
   assign adc_request_write = state == ISSUE && op == 2'b01;
   assign adc_request_read  = state == ISSUE && op == 2'b10;
   assign dac_address       = cmd[16:12];
   assign dac_data          = cmd[11:0];
   assign adc_address       = cmd[22:12];
   assign adc_data          = cmd[7:0];

   // FIFO storage: written on accepted pushes, read combinationally at the head (fall-through)
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr] <= {cmd_data[31:30], cmd_data[26:16], cmd_data[11:0]};
   end

   // FIFO pointers and occupancy
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         level  <= level + LW'(push) - LW'(pop);
      end
   end

   // Next-state logic; the shared timer counts cycles spent in the current state
   always_comb begin
      state_next  = state;
      timeout_set = 1'b0;
      case (state)
         IDLE:      state_next = empty ? IDLE : ISSUE;
         ISSUE:     state_next = op == 2'b11 ? IDLE : WAIT_BUSY;
         WAIT_BUSY: begin
            if (spi_busy) state_next = WAIT_DONE;
            else if (timer == TW'(START_TIMEOUT - 1)) begin
               timeout_set = 1'b1;
               state_next  = GAP;
            end
         end
         WAIT_DONE: state_next = spi_busy ? WAIT_DONE : (op == 2'b10 ? CAPTURE : GAP);
         CAPTURE:   state_next = GAP;
         GAP:       state_next = timer == TW'(GAP_CYCLES - 1) ? IDLE : GAP;
         default:   state_next = IDLE;
      endcase
   end

   // State register, per-state timer and latched command word
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         state <= IDLE;
         timer <= '0;
         cmd   <= '0;
      end else begin
         state <= state_next;
         timer <= state_next != state ? '0 : timer + 1'b1;
         cmd   <= pop ? mem[rd_ptr] : cmd;
      end
   end

   // Readback capture; rd_valid pulses the cycle after CAPTURE alongside the new data
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_addr  <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= state == CAPTURE;
         rd_addr  <= state == CAPTURE ? cmd[22:12] : rd_addr;
         rd_data  <= state == CAPTURE ? adc_data_readback : rd_data;
      end
   end

   // Sticky error flags (a new error beats err_clear) and registered idle status
   always_ff @(posedge sys_clk) begin
      if (!reset_n) begin
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
         seq_idle     <= 1'b1;
      end else begin
         err_overflow <= overflow_set | (err_overflow & ~err_clear);
         err_timeout  <= timeout_set | (err_timeout & ~err_clear);
         seq_idle     <= state == IDLE && empty;
      end
   end
endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb_spi_cmd_sequencer: scoreboard bench with a busy/readback model of spi_controller
`timescale 1ns/1ps
module tb_spi_cmd_sequencer;
   localparam int GAP = 4;
   localparam int TO  = 16;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] cmd_data = '0;
   logic        cmd_write = 1'b0;
   logic        err_clear = 1'b0;
   logic [7:0]  adc_data_readback = '0;
   logic        spi_busy = 1'b0;
   logic        cmd_full, err_overflow, err_timeout, seq_idle, rd_valid;
   logic [4:0]  cmd_level;
   logic [10:0] rd_addr, adc_address;
   logic [7:0]  rd_data, adc_data;
   logic        dac_request_write, adc_request_write, adc_request_read;
   logic [4:0]  dac_address;
   logic [11:0] dac_data;

   typedef struct {logic [1:0] op; logic [10:0] addr; logic [11:0] data;} req_t;
   typedef struct {logic [10:0] addr; logic [7:0] data;} rd_t;

   req_t exp_req[$];
   rd_t  exp_rd[$];
   req_t e;
   rd_t  r;
   int   tests = 0, fails = 0, cyc = 0, req_count = 0, rd_count = 0;
   int   last_req_cyc = -100, fall_cyc = -200, n, act_op;
   bit   no_busy = 1'b0;
   int   busy_len = 40;

   spi_cmd_sequencer dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .cmd_data(cmd_data), .cmd_write(cmd_write),
      .cmd_full(cmd_full), .cmd_level(cmd_level), .err_clear(err_clear),
      .err_overflow(err_overflow), .err_timeout(err_timeout), .seq_idle(seq_idle),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
      .dac_request_write(dac_request_write), .dac_address(dac_address), .dac_data(dac_data),
      .adc_request_write(adc_request_write), .adc_request_read(adc_request_read),
      .adc_address(adc_address), .adc_data(adc_data),
      .adc_data_readback(adc_data_readback), .spi_busy(spi_busy)
   );

   always #10 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_ge(input string name, input int act, input int min);
      tests++;
      if (act < min) begin
         fails++;
         $display("FAIL %s: got %0d expected at least %0d", name, act, min);
      end
   endtask

   task automatic push(input logic [31:0] w);
      cmd_data  = w;
      cmd_write = 1'b1;
      @(negedge sys_clk);
      cmd_write = 1'b0;
   endtask

   task automatic expect_req(input logic [1:0] op, input logic [10:0] addr, input logic [11:0] data);
      exp_req.push_back('{op, addr, data});
   endtask

   task automatic expect_rd(input logic [10:0] addr, input logic [7:0] data);
      exp_rd.push_back('{addr, data});
   endtask

   task automatic wait_busy(input string name, input logic want);
      int k = 0;
      while (spi_busy !== want && k < 300) begin
         @(negedge sys_clk);
         k++;
      end
      chk(name, spi_busy, want);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      repeat (3) @(negedge sys_clk);
      while (!(seq_idle && !spi_busy && exp_req.size() == 0 && exp_rd.size() == 0) && k < 3000) begin
         @(negedge sys_clk);
         k++;
      end
      chk(name, k < 3000, 1);
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(negedge sys_clk);
      err_clear = 1'b0;
      @(negedge sys_clk);
   endtask

   // spi_controller model: busy rises 2 cycles after a request and stays high busy_len cycles
   initial forever begin
      @(posedge sys_clk);
      #1;
      if (reset_n && (dac_request_write || adc_request_write || adc_request_read) && !no_busy) begin
         if (adc_request_read) adc_data_readback = adc_address[7:0] ^ 8'h5F;
         repeat (2) @(posedge sys_clk);
         #1 spi_busy = 1'b1;
         repeat (busy_len) @(posedge sys_clk);
         #1 spi_busy = 1'b0;
         fall_cyc = cyc;
      end
   end

   // Monitor: pops the scoreboard whenever a request or readback appears
   always @(negedge sys_clk) begin
      n = int'(dac_request_write) + int'(adc_request_write) + int'(adc_request_read);
      if (n != 0) begin
         chk("req_onehot", n, 1);
         req_count++;
         chk_ge("req_spacing", cyc - last_req_cyc, 3 + GAP);
         if (fall_cyc > last_req_cyc) chk_ge("gap_after_busy", cyc - fall_cyc, GAP + 1);
         last_req_cyc = cyc;
         if (exp_req.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got request with empty scoreboard");
         end else begin
            e = exp_req.pop_front();
            act_op = dac_request_write ? 0 : adc_request_write ? 1 : 2;
            chk("req_op", act_op, e.op);
            if (e.op == 2'b00) begin
               chk("dac_address", dac_address, e.addr[4:0]);
               chk("dac_data", dac_data, e.data);
            end else begin
               chk("adc_address", adc_address, e.addr);
               if (e.op == 2'b01) chk("adc_data", adc_data, e.data[7:0]);
            end
         end
      end
      if (rd_valid) begin
         rd_count++;
         if (exp_rd.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rd_valid: got rd_addr 0x%0h with empty scoreboard", rd_addr);
         end else begin
            r = exp_rd.pop_front();
            chk("rd_addr", rd_addr, r.addr);
            chk("rd_data", rd_data, r.data);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, r0, delta;
      logic [1:0]  op;
      logic [10:0] addr;
      logic [11:0] data;
      logic [31:0] w;
      // reset state
      repeat (3) @(negedge sys_clk);
      chk("rst_level", cmd_level, 0);
      chk("rst_full", cmd_full, 0);
      chk("rst_seq_idle", seq_idle, 1);
      chk("rst_errs", {err_overflow, err_timeout}, 0);
      chk("rst_reqs", {dac_request_write, adc_request_write, adc_request_read, rd_valid}, 0);
      chk("rst_outs", {dac_address, dac_data, adc_address, adc_data, rd_addr, rd_data}, 0);
      reset_n = 1'b1;
      @(negedge sys_clk);

      // DAC write
      c0 = req_count;
      push(32'h0013_0ABC);
      expect_req(2'b00, 11'h013, 12'hABC);
      wait_idle("drain_dac");
      chk("dac_req_count", req_count - c0, 1);
      chk("dac_addr_hold", dac_address, 5'h13);

      // ADC read
      push(32'h8705_0000);
      expect_req(2'b10, 11'h705, 12'h000);
      expect_rd(11'h705, 8'h5A);
      wait_idle("drain_adc_rd");
      chk("rd_addr_hold", rd_addr, 11'h705);
      chk("rd_data_hold", rd_data, 8'h5A);

      // start timeout, then the following command still runs
      no_busy = 1'b1;
      push(32'h4123_0055);
      expect_req(2'b01, 11'h123, 12'h055);
      push(32'h0005_0777);
      expect_req(2'b00, 11'h005, 12'h777);
      n = 0;
      while (!err_timeout && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      no_busy = 1'b0;
      chk("timeout_set", err_timeout, 1);
      delta = cyc - last_req_cyc;
      chk("timeout_latency_ok", delta >= TO && delta <= TO + 3, 1);
      wait_idle("drain_timeout");
      chk("timeout_sticky", err_timeout, 1);
      pulse_clear();
      chk("timeout_cleared", err_timeout, 0);

      // mixed burst with overflow, held off by a long transfer
      c0 = req_count;
      r0 = rd_count;
      push(32'h001F_0123);
      expect_req(2'b00, 11'h01F, 12'h123);
      wait_busy("burst_busy_hi", 1'b1);
      for (int i = 0; i < 16; i++) begin
         op   = 2'(i % 4);
         addr = 11'h100 + 11'(i * 17);
         data = 12'h00F + 12'(i * 273);
         w    = {op, 3'b000, addr, 4'b0000, data} | ((i % 2 == 1) ? 32'h3800_F000 : 32'h0);
         push(w);
         if (op != 2'b11) expect_req(op, addr, data);
         if (op == 2'b10) expect_rd(addr, addr[7:0] ^ 8'h5F);
      end
      chk("burst_level_full", cmd_level, 16);
      chk("burst_full", cmd_full, 1);
      chk("burst_no_ovf_yet", err_overflow, 0);
      push(32'h0002_0BAD);
      chk("burst_overflow", err_overflow, 1);
      chk("burst_level_kept", cmd_level, 16);
      wait_idle("drain_burst");
      chk("burst_req_count", req_count - c0, 13);
      chk("burst_rd_count", rd_count - r0, 4);
      pulse_clear();
      chk("ovf_cleared", err_overflow, 0);

      // full FIFO: push lands on the same edge as the IDLE pop
      push(32'h0001_0001);
      expect_req(2'b00, 11'h001, 12'h001);
      wait_busy("fp_busy_hi", 1'b1);
      for (int i = 0; i < 16; i++) begin
         push({2'b00, 3'b000, 11'(i), 4'b0000, 12'(i * 16 + 3)});
         expect_req(2'b00, 11'(i), 12'(i * 16 + 3));
      end
      chk("fp_level_full", cmd_level, 16);
      wait_busy("fp_busy_lo", 1'b0);
      repeat (5) @(negedge sys_clk);
      push(32'h001E_0EEE);
      expect_req(2'b00, 11'h01E, 12'hEEE);
      chk("fp_level_16", cmd_level, 16);
      chk("fp_no_overflow", err_overflow, 0);
      wait_idle("drain_fullpop");

      // reset while WAIT_DONE with 3 words queued
      push(32'h8200_0000);
      expect_req(2'b10, 11'h200, 12'h000);
      push(32'h0003_0111);
      push(32'h0004_0222);
      push(32'h0006_0333);
      wait_busy("rst_busy_hi", 1'b1);
      repeat (3) @(negedge sys_clk);
      chk("pre_rst_level", cmd_level, 3);
      reset_n = 1'b0;
      @(negedge sys_clk);
      reset_n = 1'b1;
      chk("mid_rst_level", cmd_level, 0);
      chk("mid_rst_reqs", {dac_request_write, adc_request_write, adc_request_read, rd_valid}, 0);
      chk("mid_rst_seq_idle", seq_idle, 1);
      c0 = req_count;
      r0 = rd_count;
      repeat (80) @(negedge sys_clk);
      chk("post_rst_no_req", req_count - c0, 0);
      chk("post_rst_no_rd", rd_count - r0, 0);
      chk("post_rst_rd_data", {rd_addr, rd_data}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
